// File: rtl/speck_hash_arbiter_pkg.sv
// Shared definitions for the SPECK hash arbiter slice.
// Contents:
//   arb_state_e  - arbiter FSM state (IDLE -> LOAD -> RUN -> RESP -> IDLE)
//   DEF_NREQ     - default number of requesters
//   DEF_TIMEOUT  - default core timeout in cycles
//   id_width()   - width of a requester index for a given requester count
//   rr_slot()    - modular offset from the round-robin pointer
package speck_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 255;

    // Two requesters still need one index bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // (base + off) mod n for base < n and off < n.
    function automatic int rr_slot(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/speck_hash_arbiter_if.sv
// Control/data path between the arbiter and the SPECK hash core.
// Handshake: the master pulses core_start for exactly one cycle with core_x
// valid and holds core_x until it starts another operation; the core answers
// with a one-cycle core_done pulse, core_hout being valid only in that cycle.
// There is no back-pressure; a core_done the master is not waiting for is
// dropped.
//   master : arbiter side (drives core_start, core_x)
//   slave  : hash core side (drives core_done, core_hout)
interface speck_hash_arbiter_if;
    logic        core_start;
    logic [63:0] core_x;
    logic        core_done;
    logic [3:0]  core_hout;

    modport master (output core_start, output core_x, input core_done, input core_hout);
    modport slave  (input core_start, input core_x, output core_done, output core_hout);
endinterface

// File: rtl/speck_hash_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req     - request vector
//   ptr     - index searched first; search continues upward with wrap
//   winner  - one-hot winner (zero when no request)
//   index   - binary index of the winner
//   any_req - at least one request present
module rr_arbiter
    import speck_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] winner,
    output logic [IDW-1:0]  index,
    output logic            any_req
);

    // Walk from the farthest slot back to ptr so the nearest request is
    // written last and wins.
    always_comb begin
        winner  = '0;
        index   = '0;
        any_req = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (|(req & (NREQ'(1) << rr_slot(int'(ptr), k, NREQ)))) begin
                winner = NREQ'(1) << rr_slot(int'(ptr), k, NREQ);
                index  = IDW'(rr_slot(int'(ptr), k, NREQ));
            end
        end
    end

endmodule

// File: rtl/speck_hash_arbiter.sv
// Shares one SPECK hash core among NREQ requesters. A winner is chosen
// round-robin, its message word is handed to the core, and the result (or a
// timeout error) is returned on the response strobe.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req, req_x   - per-requester request level and packed 64-bit messages
//   gnt          - one-hot grant held from LOAD through RESP
//   busy         - FSM not in IDLE
//   core         - hash core control/data path (master side)
//   rsp_valid    - one-cycle response strobe with rsp_id/rsp_hash/rsp_err
//   state        - current FSM state, for observation
module speck_hash_arbiter
    import speck_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IDW    = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*64-1:0]     req_x,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    speck_hash_arbiter_if.master   core,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [3:0]             rsp_hash,
    output logic                   rsp_err,
    output arb_state_e             state
);

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    arb_state_e      state_nx;
    logic [IDW-1:0]  ptr;
    logic [7:0]      cnt;
    logic [63:0]     core_x_q;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic            any_req;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .winner  (win_oh),
        .index   (win_idx),
        .any_req (any_req)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; core_done is only looked at in RUN.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (any_req) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_RUN;
            ST_RUN:  if (core.core_done || cnt == TIMEOUT_M1) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy            = (state != ST_IDLE);
        core.core_start = (state == ST_LOAD);
        rsp_valid       = (state == ST_RESP);
    end

    assign core.core_x = core_x_q;

    // Grant, message, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            rsp_id   <= '0;
            core_x_q <= '0;
            rsp_hash <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt      <= win_oh;
                        rsp_id   <= win_idx;
                        core_x_q <= 64'(req_x >> (64 * int'(win_idx)));
                    end
                end
                ST_LOAD: cnt <= '0;
                ST_RUN: begin
                    cnt <= cnt + 8'd1;
                    // A done arriving on the last allowed cycle still counts.
                    if (core.core_done) begin
                        rsp_hash <= core.core_hout;
                        rsp_err  <= 1'b0;
                    end else if (cnt == TIMEOUT_M1) begin
                        rsp_hash <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // The requester just served drops to lowest priority.
                    ptr <= (int'(rsp_id) == NREQ - 1) ? '0 : rsp_id + 1'b1;
                    gnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_speck_hash_arbiter.sv
module tb_speck_hash_arbiter;
    import speck_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 24;
    localparam int IDW  = id_width(NREQ);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*64-1:0] req_x = '0;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [3:0]         rsp_hash;
    logic               rsp_err;
    arb_state_e         state;

    speck_hash_arbiter_if core_if ();

    speck_hash_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_x     (req_x),
        .gnt       (gnt),
        .busy      (busy),
        .core      (core_if),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_hash  (rsp_hash),
        .rsp_err   (rsp_err),
        .state     (state)
    );

    // ---------------- scoreboard data ----------------
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [3:0]     hash;
        logic           err;
        logic [63:0]    x;
        logic [7:0]     delta;
    } exp_t;
    localparam int EW = $bits(exp_t);

    typedef struct packed {
        logic [63:0] x;
        logic [7:0]  lat;   // cycles from core_start to core_done; 0 = never
        logic [3:0]  hout;
    } job_t;

    logic [EW-1:0] exp_q[$];
    logic [63:0]   xq[$];
    logic [11:0]   core_q[$];   // {lat, hout} per core_start in service order

    job_t job_tab[NREQ][8];
    int   job_n[NREQ];
    int   model_ptr = 0;

    int err_cnt = 0;
    int chk_cnt = 0;

    int phase_id = 0;
    int raise_cyc = 0;
    int stray_req_id = 0;
    logic idle_stray = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        chk_cnt++;
        if (act !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic set_x(input int i, input logic [63:0] x);
        logic [NREQ*64-1:0] m;
        m = {{((NREQ-1)*64){1'b0}}, {64{1'b1}}} << (64 * i);
        req_x = (req_x & ~m) | ({{((NREQ-1)*64){1'b0}}, x} << (64 * i));
    endtask

    // ---------------- core model ----------------
    logic       model_done = 1'b0;
    logic [3:0] model_hout = '0;
    logic       stray_done = 1'b0;

    assign core_if.core_done = model_done | stray_done | idle_stray;
    assign core_if.core_hout = (stray_done | idle_stray) ? 4'hF : model_hout;

    initial begin
        int cd;
        int stray_done_id;
        logic [3:0] cur_hout;
        logic [11:0] b;
        cd = -1;
        stray_done_id = 0;
        cur_hout = '0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            stray_done = 1'b0;
            if (!rst_n) begin
                cd = -1;
            end else if (core_if.core_start) begin
                if (core_q.size() == 0) begin
                    check("core_start_unplanned", 64'(core_if.core_start), 64'd0);
                    cd = -1;
                end else begin
                    b = core_q.pop_front();
                    cd = (b[11:4] == 8'd0) ? -1 : int'(b[11:4]);
                    cur_hout = b[3:0];
                end
                // Spurious done during LOAD, must be ignored.
                if (stray_req_id != stray_done_id) begin
                    stray_done = 1'b1;
                    stray_done_id = stray_req_id;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    model_done = 1'b1;
                    model_hout = cur_hout;
                    cd = -1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int seen_phase;
        int start_cyc;
        int last_rsp_cyc;
        logic [NREQ-1:0] gnt_at_start;
        exp_t e;
        seen_phase = 0;
        start_cyc = 0;
        last_rsp_cyc = 0;
        gnt_at_start = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) check("gnt_onehot", 64'($onehot(gnt)), 64'd1);
                else      check("gnt_idle_zero", 64'(gnt), 64'd0);
                if (core_if.core_start) begin
                    start_cyc = cyc;
                    gnt_at_start = gnt;
                    if (phase_id != seen_phase) begin
                        check("req_to_start_latency", 64'(cyc - raise_cyc), 64'd1);
                        seen_phase = phase_id;
                    end else begin
                        check("grant_gap", 64'(cyc - last_rsp_cyc), 64'd2);
                    end
                    if (xq.size() == 0) check("start_unexpected", 64'd1, 64'd0);
                    else check("core_x", core_if.core_x, xq.pop_front());
                end
                if (rsp_valid) begin
                    last_rsp_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_t'(exp_q.pop_front());
                        check("rsp_id", 64'(rsp_id), 64'(e.id));
                        check("rsp_hash", 64'(rsp_hash), 64'(e.hash));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                        check("rsp_latency", 64'(cyc - start_cyc), 64'(e.delta));
                        check("gnt_at_rsp", 64'(gnt), 64'(NREQ'(1) << e.id));
                        check("gnt_stable", 64'(gnt), 64'(gnt_at_start));
                        check("core_x_hold", core_if.core_x, e.x);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Reference model: with every pending requester holding req until its
    // jobs are done, the service order is a pure round-robin walk over the
    // job counts starting at model_ptr.
    task automatic run_phase(input bit drop_early, input bit stray);
        int rem[NREQ];
        int head[NREQ];
        int order_q[$];
        int p;
        int w;
        int n_left;
        bit got;
        job_t j;
        exp_t e;
        p = model_ptr;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = job_n[i];
            head[i] = 0;
        end
        forever begin
            n_left = 0;
            for (int i = 0; i < NREQ; i++) n_left += rem[i];
            if (n_left == 0) break;
            w = p;
            for (int k = 0; k < NREQ; k++) begin
                w = (p + k) % NREQ;
                if (rem[w] > 0) break;
            end
            j = job_tab[w][job_n[w] - rem[w]];
            e.id = IDW'(w);
            e.x = j.x;
            if (j.lat != 8'd0 && int'(j.lat) <= TMO) begin
                e.hash = j.hout;
                e.err = 1'b0;
                e.delta = j.lat + 8'd1;
            end else begin
                e.hash = 4'h0;
                e.err = 1'b1;
                e.delta = 8'(TMO + 1);
            end
            exp_q.push_back(EW'(e));
            xq.push_back(j.x);
            core_q.push_back({j.lat, j.hout});
            order_q.push_back(w);
            rem[w]--;
            p = (w + 1) % NREQ;
        end
        model_ptr = p;

        @(negedge clk);
        phase_id++;
        raise_cyc = cyc;
        if (stray) stray_req_id++;
        for (int i = 0; i < NREQ; i++) begin
            if (job_n[i] > 0) begin
                req[i] = 1'b1;
                set_x(i, job_tab[i][0].x);
            end
        end
        foreach (order_q[k]) begin
            got = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (drop_early && core_if.core_start) req = '0;
                if (rsp_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                check("rsp_wait_timeout", 64'd0, 64'd1);
                req = '0;
                break;
            end
            w = order_q[k];
            head[w]++;
            if (head[w] >= job_n[w]) req[w] = 1'b0;
            else set_x(w, job_tab[w][head[w]].x);
        end
        for (int i = 0; i < NREQ; i++) job_n[i] = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic add_job(input int i, input logic [63:0] x, input int lat, input logic [3:0] h);
        job_tab[i][job_n[i]].x = x;
        job_tab[i][job_n[i]].lat = 8'(lat);
        job_tab[i][job_n[i]].hout = h;
        job_n[i]++;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < NREQ; i++) job_n[i] = 0;

        // Reset state
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_core_start", 64'(core_if.core_start), 64'd0);
        check("rst_core_x", core_if.core_x, 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_hash", 64'(rsp_hash), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_state", 64'(state), 64'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // core_done while idle is ignored
        idle_stray = 1'b1;
        @(negedge clk);
        idle_stray = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_done_busy", 64'(busy), 64'd0);
        end

        // All four requesting, requester 0 twice: order 0,1,2,3,0
        add_job(0, 64'hA0A0_0000_0000_0001, 3, 4'h1);
        add_job(0, 64'hA0A0_0000_0000_0005, 6, 4'h5);
        add_job(1, 64'hB1B1_0000_0000_0002, 4, 4'h2);
        add_job(2, 64'hC2C2_0000_0000_0003, 5, 4'h3);
        add_job(3, 64'hD3D3_0000_0000_0004, 2, 4'h4);
        run_phase(1'b0, 1'b0);

        // Single request, 20-cycle core
        add_job(0, 64'h1234_5678_9ABC_DEF1, 20, 4'hA);
        run_phase(1'b0, 1'b0);

        // Core never answers: timeout
        add_job(1, 64'hDEAD_BEEF_0000_0011, 0, 4'h7);
        run_phase(1'b0, 1'b0);

        // core_done on the last timeout cycle wins
        add_job(2, 64'h0BAD_F00D_0000_0022, TMO, 4'h5);
        run_phase(1'b0, 1'b0);

        // Spurious core_done during LOAD is ignored
        add_job(3, 64'h5555_AAAA_5555_AAAA, 7, 4'h9);
        run_phase(1'b0, 1'b1);

        // req dropped right after grant still gets a response
        add_job(1, 64'h0F0F_0F0F_F0F0_F0F0, 8, 4'hC);
        run_phase(1'b1, 1'b0);

        // Randomized phases
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++)
                    add_job(i, {$urandom, $urandom},
                            ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 4),
                            4'($urandom_range(0, 15)));
            end
            if (job_n[0] + job_n[1] + job_n[2] + job_n[3] == 0)
                add_job($urandom_range(0, NREQ - 1), {$urandom, $urandom}, $urandom_range(1, 10), 4'hE);
            run_phase(1'b0, 1'b0);
        end

        // Leave the pointer at 3 before the reset test
        add_job(2, 64'h2222_0000_2222_0000, 4, 4'h2);
        run_phase(1'b0, 1'b0);

        // Reset during RUN discards the operation
        @(negedge clk);
        phase_id++;
        raise_cyc = cyc;
        req[2] = 1'b1;
        set_x(2, 64'h7777_6666_5555_4444);
        xq.push_back(64'h7777_6666_5555_4444);
        core_q.push_back({8'd0, 4'h0});
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (core_if.core_start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("reset_test_start", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_core_start", 64'(core_if.core_start), 64'd0);
        check("mid_rst_core_x", core_if.core_x, 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
        check("mid_rst_rsp_hash", 64'(rsp_hash), 64'd0);
        check("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        repeat (2) @(negedge clk);

        // After reset the search starts at 0, so 2 precedes 3
        add_job(2, 64'h2020_2020_2020_2020, 9, 4'h6);
        add_job(3, 64'h3030_3030_3030_3030, 5, 4'hB);
        run_phase(1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("xq_drained", 64'(xq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/speck_hash_arbiter.md
SPECK_HASH_ARBITER -- requirements
Module: speck_hash_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one SPECK hash core (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum core cycles from start to done before abort (1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, NREQ, per-requester hash request level.
REQ-006 SHALL have port req_x, input, NREQ*64, packed 64-bit message words; requester i occupies bits [64*i+63:64*i].
REQ-007 SHALL have port gnt, output, NREQ, one-hot grant, or all zero.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port core_start, output, 1, single-cycle start pulse to the hash control path.
REQ-010 SHALL have port core_x, output, 64, message word driven to datapath X.
REQ-011 SHALL have port core_done, input, 1, completion pulse from the core.
REQ-012 SHALL have port core_hout, input, 4, core hash result, valid while core_done is high.
REQ-013 SHALL have port rsp_valid, output, 1, single-cycle response strobe.
REQ-014 SHALL have port rsp_id, output, clog2(NREQ), index of the requester being answered.
REQ-015 SHALL have port rsp_hash, output, 4, captured hash.
REQ-016 SHALL have port rsp_err, output, 1, high with rsp_valid when the operation timed out.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> RUN -> RESP -> IDLE.
REQ-018 In IDLE with any req bit set, SHALL pick a winner round-robin, starting the search at pointer ptr, and go to LOAD.
REQ-019 On leaving IDLE, SHALL register gnt, the winner id and core_x = req_x[winner].
REQ-020 In LOAD, SHALL assert core_start for exactly one cycle, clear the timeout counter and go to RUN.
REQ-021 In RUN, SHALL increment the 8-bit timeout counter each cycle.
REQ-022 In RUN, on core_done SHALL capture core_hout into rsp_hash, clear err and go to RESP.
REQ-023 In RUN, when the counter equals TIMEOUT-1 without core_done, SHALL set err, set rsp_hash to 0 and go to RESP.
REQ-024 If core_done and timeout coincide, core_done SHALL win (err = 0).
REQ-025 In RESP, SHALL assert rsp_valid for one cycle with rsp_id, rsp_hash and rsp_err.
REQ-026 In RESP, SHALL set ptr = (id+1) mod NREQ, clear gnt and return to IDLE.
REQ-027 gnt SHALL remain stable and one-hot from LOAD through RESP inclusive.
REQ-028 core_x SHALL be held constant from LOAD until the next grant.
REQ-029 Dropping req during LOAD/RUN SHALL NOT abort the operation; the response is still issued.
REQ-030 A requester holding req after its response SHALL re-arbitrate at lowest priority.
REQ-031 core_done outside RUN SHALL be ignored.
REQ-032 A req change in LOAD/RUN/RESP SHALL NOT affect the current grant.
REQ-033 Minimum latency SHALL be 3 cycles plus core latency from req sampled in IDLE to rsp_valid; back-to-back grants SHALL be separated by exactly one IDLE cycle.

Reset
REQ-034 While rst_n is low, SHALL force state IDLE, ptr 0, counter 0, and gnt, busy, core_start, core_x, rsp_valid, rsp_id, rsp_hash and rsp_err to 0, asynchronously.
REQ-035 Reset asserted mid-RUN SHALL discard the operation without a response; the first grant after reset SHALL follow REQ-018 with ptr 0.

Structure
REQ-036 Package speck_arb_pkg SHALL hold the FSM state enum, default NREQ, default TIMEOUT and the ID width function.
REQ-037 Round-robin winner selection SHALL be a combinational sub-module rr_arbiter (inputs req and ptr; outputs one-hot winner, index and any_req).

Verification
REQ-038 Single request: req=0001, req_x[0]=64'h123456789ABCDEF1, core model returns done after 20 cycles with hout 4'hA -> one core_start pulse, core_x=123456789ABCDEF1, rsp_valid with id 0, hash A, err 0.
REQ-039 All four requesting simultaneously, held high -> service order 0,1,2,3,0; gnt one-hot throughout; one IDLE cycle between grants.
REQ-040 TIMEOUT=16, core never done -> rsp_valid with rsp_err=1 and rsp_hash=0, 16 cycles after the RUN entry cycle.
REQ-041 core_done on the final timeout cycle with hout 4'h5 -> rsp_err=0, rsp_hash=5.
REQ-042 rst_n low for 2 cycles during RUN -> all outputs 0 immediately, no rsp_valid, and the next request from requester 2 is served normally.
REQ-043 core_done pulsed in IDLE and LOAD -> ignored; no rsp_valid and no state change.
